int_to_raw_fn_normalizer: RTL and testbench



---
 rtl/int_to_raw_fn_normalizer.sv | 164 ++++++++++++++++
 tb/tb_int_to_raw_fn_normalizer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/int_to_raw_fn_normalizer.sv
// int_to_raw_fn_normalizer
//
// Integer-to-raw-float front end for the FPU int->float path. It accepts a
// 64-bit signed or unsigned integer and takes its magnitude. It then
// normalises the magnitude so the leading one sits in bit 63. The result is
// presented as a raw float: isZero, sign, 9-bit sExp and 65-bit sig, plus the
// captured rounding mode. The exponent follows the sExp + 0x80 convention of
// the single-precision raw->recFN rounding stage.
//
// Build option:
//   RAWFN_SINGLE_CYCLE_NORM_EN
//     Defined:   NORM does a full 64-bit priority encode and shift in one
//                cycle.
//     Undefined: NORM steps 8 bits per cycle with coarse steps, then does one
//                fine step.
//   Both builds produce identical results; only the latency differs.
//
// Ports:
//   clock                    rising-edge clock
//   reset                    synchronous, active-low (0 = reset)
//   io_in_valid/io_in_ready  request handshake (ready only in IDLE)
//   io_in_bits_signedIn      1 = operand is two's complement
//   io_in_bits_in            64-bit integer operand
//   io_in_bits_roundingMode  rounding mode, carried to the output
//   io_out_valid/io_out_ready result handshake (held until accepted)
//   io_out_isZero            operand was zero
//   io_out_sign              result sign
//   io_out_sExp              raw exponent, 9'hBF - leadingZeros
//   io_out_sig               {1'b0, normalised magnitude}, bit 63 = hidden bit
//   io_out_roundingMode      captured rounding mode

module int_to_raw_fn_normalizer (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic        io_in_bits_signedIn,
  input  logic [63:0] io_in_bits_in,
  input  logic [2:0]  io_in_bits_roundingMode,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic        io_out_isZero,
  output logic        io_out_sign,
  output logic [8:0]  io_out_sExp,
  output logic [64:0] io_out_sig,
  output logic [2:0]  io_out_roundingMode
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} stateT;

  stateT       state, nextState;
  logic        signReg, nextSign;
  logic        isZeroReg, nextIsZero;
  logic [63:0] magReg, nextMag;
  logic [5:0]  lzReg, nextLz;
  logic [2:0]  rmReg, nextRm;
  logic        done;

`ifdef RAWFN_SINGLE_CYCLE_NORM_EN
  // Leading-zero count of a nonzero 64-bit value. The highest set bit is
  // the last one to assign, so it wins.
  function automatic logic [5:0] lzc64(input logic [63:0] v);
    lzc64 = 6'd0;
    for (int i = 0; i < 64; i++)
      if (v[i]) lzc64 = 6'(63 - i);
  endfunction

  logic [5:0] fullLz;
  assign fullLz = lzc64(magReg);
`else
  // Leading-zero count of the top byte. The result is only used when the
  // byte is nonzero.
  function automatic logic [2:0] lzc8(input logic [7:0] v);
    lzc8 = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) lzc8 = 3'(7 - i);
  endfunction

  logic [2:0] fineLz;
  assign fineLz = lzc8(magReg[63:56]);
`endif

  // Only accept while running and idle, so a request is never taken while
  // reset is asserted.
  assign io_in_ready = reset && (state == IDLE);

  // Next-state and datapath update. Each register holds its value unless
  // the current state changes it.
  always_comb begin
    nextState  = state;
    nextSign   = signReg;
    nextIsZero = isZeroReg;
    nextMag    = magReg;
    nextLz     = lzReg;
    nextRm     = rmReg;
    case (state)
      IDLE: begin
        if (io_in_valid && io_in_ready) begin
          nextSign   = io_in_bits_signedIn & io_in_bits_in[63];
          // The most negative value negates to itself. As an unsigned
          // value that is exactly 2^63, which is the correct magnitude.
          nextMag    = nextSign ? (~io_in_bits_in + 64'd1) : io_in_bits_in;
          nextRm     = io_in_bits_roundingMode;
          nextLz     = 6'd0;
          nextIsZero = (nextMag == 64'd0);
          nextState  = nextIsZero ? DONE : NORM;
        end
      end
      NORM: begin
`ifdef RAWFN_SINGLE_CYCLE_NORM_EN
        nextLz    = fullLz;
        nextMag   = magReg << fullLz;
        nextState = DONE;
`else
        // Coarse steps skip whole zero bytes. One fine step always ends
        // the sequence, even when the top bit is already set.
        if (magReg[63:56] == 8'd0) begin
          nextMag = magReg << 8;
          nextLz  = lzReg + 6'd8;
        end else begin
          nextMag   = magReg << fineLz;
          nextLz    = lzReg + {3'b000, fineLz};
          nextState = DONE;
        end
`endif
      end
      DONE: begin
        if (io_out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // State and datapath registers. A reset in any state abandons the
  // operation in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      signReg   <= 1'b0;
      isZeroReg <= 1'b0;
      magReg    <= 64'd0;
      lzReg     <= 6'd0;
      rmReg     <= 3'd0;
    end else begin
      state     <= nextState;
      signReg   <= nextSign;
      isZeroReg <= nextIsZero;
      magReg    <= nextMag;
      lzReg     <= nextLz;
      rmReg     <= nextRm;
    end
  end

  // Outputs are zero outside DONE, so partial results are never visible.
  // A zero operand gives sExp = 0, not 9'hBF.
  assign done                = (state == DONE);
  assign io_out_valid        = done;
  assign io_out_isZero       = done & isZeroReg;
  assign io_out_sign         = done & signReg;
  assign io_out_sExp         = (done && !isZeroReg) ? (9'h0BF - {3'b000, lzReg}) : 9'h000;
  assign io_out_sig          = done ? {1'b0, magReg} : 65'd0;
  assign io_out_roundingMode = done ? rmReg : 3'd0;

endmodule

// File: tb/tb_int_to_raw_fn_normalizer.sv
// Testbench for int_to_raw_fn_normalizer.
// It applies directed operands whose expected raw-float fields and latencies
// were computed by hand. It also exercises output back-pressure and a reset
// in the middle of an operation.

module tb_int_to_raw_fn_normalizer;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic        io_in_bits_signedIn;
  logic [63:0] io_in_bits_in;
  logic [2:0]  io_in_bits_roundingMode;
  logic        io_out_valid;
  logic        io_out_ready;
  logic        io_out_isZero;
  logic        io_out_sign;
  logic [8:0]  io_out_sExp;
  logic [64:0] io_out_sig;
  logic [2:0]  io_out_roundingMode;

  int compareCount  = 0;
  int mismatchCount = 0;

  int_to_raw_fn_normalizer dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_in_valid             (io_in_valid),
    .io_in_ready             (io_in_ready),
    .io_in_bits_signedIn     (io_in_bits_signedIn),
    .io_in_bits_in           (io_in_bits_in),
    .io_in_bits_roundingMode (io_in_bits_roundingMode),
    .io_out_valid            (io_out_valid),
    .io_out_ready            (io_out_ready),
    .io_out_isZero           (io_out_isZero),
    .io_out_sign             (io_out_sign),
    .io_out_sExp             (io_out_sExp),
    .io_out_sig              (io_out_sig),
    .io_out_roundingMode     (io_out_roundingMode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts one comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [64:0] observed,
                             input logic [64:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request and measures the latency from the accept edge. It
  // checks every output field, stalls the result for holdCycles cycles, and
  // then releases it.
  task automatic applyStimulus(input string name, input logic signedIn,
                               input logic [63:0] operand, input logic [2:0] rm,
                               input logic expSign, input logic expZero,
                               input logic [8:0] expSExp, input logic [64:0] expSig,
                               input int expLatIter, input int holdCycles);
    int lat;
    int expLat;
    logic [64:0] heldSig;
    expLat = expLatIter;
`ifdef RAWFN_SINGLE_CYCLE_NORM_EN
    if (!expZero) expLat = 2;
`endif
    @(negedge clock);
    checkOutput({name, ".inReady"}, 65'(io_in_ready), 65'd1);
    io_in_valid             = 1'b1;
    io_in_bits_signedIn     = signedIn;
    io_in_bits_in           = operand;
    io_in_bits_roundingMode = rm;
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    io_in_bits_in = 64'hDEAD_BEEF_DEAD_BEEF;
    lat = 1;
    @(negedge clock);
    while (!io_out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput({name, ".latency"}, 65'(lat), 65'(expLat));
    checkOutput({name, ".sign"},   65'(io_out_sign),   65'(expSign));
    checkOutput({name, ".isZero"}, 65'(io_out_isZero), 65'(expZero));
    checkOutput({name, ".sExp"},   65'(io_out_sExp),   65'(expSExp));
    checkOutput({name, ".sig"},    io_out_sig,         expSig);
    checkOutput({name, ".rm"},     65'(io_out_roundingMode), 65'(rm));
    heldSig = expSig;
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clock);
      checkOutput({name, ".holdValid"},   65'(io_out_valid), 65'd1);
      checkOutput({name, ".holdSig"},     io_out_sig,        heldSig);
      checkOutput({name, ".holdSExp"},    65'(io_out_sExp),  65'(expSExp));
      checkOutput({name, ".holdInReady"}, 65'(io_in_ready),  65'd0);
    end
    io_out_ready = 1'b1;
    @(posedge clock);
    #1 io_out_ready = 1'b0;
    @(negedge clock);
    checkOutput({name, ".afterValid"},   65'(io_out_valid), 65'd0);
    checkOutput({name, ".afterInReady"}, 65'(io_in_ready),  65'd1);
  endtask

  initial begin
    reset                   = 1'b0;
    io_in_valid             = 1'b0;
    io_in_bits_signedIn     = 1'b0;
    io_in_bits_in           = 64'd0;
    io_in_bits_roundingMode = 3'd0;
    io_out_ready            = 1'b0;

    // State while reset is held.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset.inReady",  65'(io_in_ready),  65'd0);
    checkOutput("reset.outValid", 65'(io_out_valid), 65'd0);
    checkOutput("reset.sig",      io_out_sig,        65'd0);
    checkOutput("reset.sExp",     65'(io_out_sExp),  65'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset.readyAfter", 65'(io_in_ready), 65'd1);

    applyStimulus("negOne", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0,
                  1'b1, 1'b0, 9'h080, 65'h0_8000_0000_0000_0000, 9, 5);
    applyStimulus("uMin63", 1'b0, 64'h8000_0000_0000_0000, 3'd1,
                  1'b0, 1'b0, 9'h0BF, 65'h0_8000_0000_0000_0000, 2, 0);
    applyStimulus("sMinInt", 1'b1, 64'h8000_0000_0000_0000, 3'd2,
                  1'b1, 1'b0, 9'h0BF, 65'h0_8000_0000_0000_0000, 2, 0);
    applyStimulus("u0x100", 1'b0, 64'h0000_0000_0000_0100, 3'd4,
                  1'b0, 1'b0, 9'h088, 65'h0_8000_0000_0000_0000, 8, 0);
    applyStimulus("zero", 1'b0, 64'h0, 3'd3,
                  1'b0, 1'b1, 9'h000, 65'h0, 1, 2);
    applyStimulus("negFive", 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 3'd1,
                  1'b1, 1'b0, 9'h082, 65'h0_A000_0000_0000_0000, 9, 0);
    applyStimulus("mixed", 1'b0, 64'h0000_0123_4567_89AB, 3'd0,
                  1'b0, 1'b0, 9'h0A8, 65'h0_91A2_B3C4_D580_0000, 4, 0);
    applyStimulus("sMaxPos", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'd7,
                  1'b0, 1'b0, 9'h0BE, 65'h0_FFFF_FFFF_FFFF_FFFE, 2, 0);

    // Reset asserted during the third NORM cycle of operand 1.
    @(negedge clock);
    io_in_valid         = 1'b1;
    io_in_bits_signedIn = 1'b0;
    io_in_bits_in       = 64'd1;
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abort.outValid", 65'(io_out_valid), 65'd0);
    checkOutput("abort.inReady",  65'(io_in_ready),  65'd0);
    checkOutput("abort.sig",      io_out_sig,        65'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort.outValidAfter", 65'(io_out_valid), 65'd0);
    applyStimulus("postAbort", 1'b0, 64'd1, 3'd5,
                  1'b0, 1'b0, 9'h080, 65'h0_8000_0000_0000_0000, 9, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
